// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready stage with registered ready and valid.
// Ports: clk_i, rst_i (sync, high); s_valid_i/s_ready_o/s_data_i producer side;
//        m_valid_o/m_ready_i/m_data_o consumer side; fill_o occupancy 0..2.
module skid_buffer #(
    parameter int G_DATA_SIZE = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [G_DATA_SIZE-1:0] s_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [G_DATA_SIZE-1:0] m_data_o,
    output logic [1:0]             fill_o
);

    typedef enum logic [1:0] {
        S_INIT,
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                   s_fire;
    logic                   m_fire;
    logic                   out_ld;
    logic                   out_from_skid;
    logic                   skid_ld;
    logic                   ready_d;
    logic                   valid_d;
    logic [1:0]             fill_d;
    logic [G_DATA_SIZE-1:0] skid_q;

    assign s_fire = s_valid_i & s_ready_o;
    assign m_fire = m_valid_o & m_ready_i;

    always_comb begin
        state_d       = state_q;
        out_ld        = 1'b0;
        out_from_skid = 1'b0;
        skid_ld       = 1'b0;
        unique case (state_q)
            S_INIT: begin
                state_d = S_EMPTY;
            end
            S_EMPTY: begin
                if (s_fire) begin
                    out_ld  = 1'b1;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (s_fire && !m_fire) begin
                    skid_ld = 1'b1;
                    state_d = S_TWO;
                end else if (s_fire && m_fire) begin
                    out_ld = 1'b1;
                end else if (m_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (m_fire) begin
                    out_ld        = 1'b1;
                    out_from_skid = 1'b1;
                    state_d       = S_ONE;
                end
            end
        endcase
    end

    // Handshake outputs are decoded from the next state and registered,
    // so s_ready_o has no combinational dependence on m_ready_i.
    always_comb begin
        ready_d = 1'b0;
        valid_d = 1'b0;
        fill_d  = 2'd0;
        unique case (state_d)
            S_INIT: begin
                ready_d = 1'b0;
            end
            S_EMPTY: begin
                ready_d = 1'b1;
            end
            S_ONE: begin
                ready_d = 1'b1;
                valid_d = 1'b1;
                fill_d  = 2'd1;
            end
            S_TWO: begin
                valid_d = 1'b1;
                fill_d  = 2'd2;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_INIT;
            s_ready_o <= 1'b0;
            m_valid_o <= 1'b0;
            fill_o    <= 2'd0;
        end else begin
            state_q   <= state_d;
            s_ready_o <= ready_d;
            m_valid_o <= valid_d;
            fill_o    <= fill_d;
        end
    end

    // Data registers carry no reset; contents are qualified by m_valid_o.
    always_ff @(posedge clk_i) begin
        if (out_ld) begin
            m_data_o <= out_from_skid ? skid_q : s_data_i;
        end
        if (skid_ld) begin
            skid_q <= s_data_i;
        end
    end

endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed checks of skid_buffer handshake, order and reset.
// Ports: none; drives and samples the DUT 1 ns after each rising edge.
module tb_skid_buffer;

    logic       clk_i;
    logic       rst_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] s_data_i;
    logic       m_valid_o;
    logic       m_ready_i;
    logic [7:0] m_data_o;
    logic [1:0] fill_o;

    int n_checks = 0;
    int n_errors = 0;

    skid_buffer #(
        .G_DATA_SIZE(8)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .s_data_i (s_data_i),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .m_data_o (m_data_o),
        .fill_o   (fill_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic rdy,
                          input logic vld, input logic [1:0] fill);
        chk({tag, ".s_ready"}, 16'(s_ready_o), 16'(rdy));
        chk({tag, ".m_valid"}, 16'(m_valid_o), 16'(vld));
        chk({tag, ".fill"}, 16'(fill_o), 16'(fill));
    endtask

    initial begin
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = 8'h00;
        m_ready_i = 1'b0;

        // reset then idle
        step();
        chk_st("rst1", 1'b0, 1'b0, 2'd0);
        step();
        rst_i = 1'b0;
        chk_st("rst2", 1'b0, 1'b0, 2'd0);
        step();
        chk_st("idle", 1'b1, 1'b0, 2'd0);

        // single word
        s_valid_i = 1'b1;
        s_data_i  = 8'h5A;
        m_ready_i = 1'b1;
        step();
        s_valid_i = 1'b0;
        chk_st("single", 1'b1, 1'b1, 2'd1);
        chk("single.data", 16'(m_data_o), 16'h005A);
        step();
        chk_st("single_done", 1'b1, 1'b0, 2'd0);

        // streaming 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = 8'(i);
            step();
            chk("stream.s_ready", 16'(s_ready_o), 16'h1);
            chk("stream.m_valid", 16'(m_valid_o), 16'h1);
            chk("stream.data", 16'(m_data_o), 16'(i));
        end
        s_valid_i = 1'b0;
        step();
        chk_st("stream_done", 1'b1, 1'b0, 2'd0);

        // backpressure fill
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = 8'hA1;
        step();
        chk_st("bp1", 1'b1, 1'b1, 2'd1);
        chk("bp1.data", 16'(m_data_o), 16'h00A1);
        s_data_i = 8'hA2;
        step();
        chk_st("bp2", 1'b0, 1'b1, 2'd2);
        chk("bp2.data", 16'(m_data_o), 16'h00A1);
        s_data_i = 8'hA3;
        step();
        chk_st("bp3", 1'b0, 1'b1, 2'd2);
        chk("bp3.data", 16'(m_data_o), 16'h00A1);
        step();
        chk_st("bp4", 1'b0, 1'b1, 2'd2);
        chk("bp4.data", 16'(m_data_o), 16'h00A1);

        // drain: A1 leaves on this edge, A2 comes from skid
        m_ready_i = 1'b1;
        step();
        chk_st("drain1", 1'b1, 1'b1, 2'd1);
        chk("drain1.data", 16'(m_data_o), 16'h00A2);
        step();
        s_valid_i = 1'b0;
        chk_st("drain2", 1'b1, 1'b1, 2'd1);
        chk("drain2.data", 16'(m_data_o), 16'h00A3);
        step();
        chk_st("drain3", 1'b1, 1'b0, 2'd0);

        // reset while full
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = 8'hB1;
        step();
        s_data_i = 8'hB2;
        step();
        chk_st("full", 1'b0, 1'b1, 2'd2);
        rst_i     = 1'b1;
        m_ready_i = 1'b1;
        s_valid_i = 1'b0;
        step();
        rst_i = 1'b0;
        chk_st("rst_full", 1'b0, 1'b0, 2'd0);
        step();
        chk_st("rst_full2", 1'b1, 1'b0, 2'd0);
        step();
        chk_st("rst_full3", 1'b1, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
